// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: WIDTH-bit carry-lookahead adder built from GROUP-bit
// CLA slices, one slice per pipeline stage, with valid/ready handshakes on
// both the operand and the result side.
//
// Optional build macro: CLA_ADD_SUB_EN
//   Adds a 'sub' input. When sub=1 the block computes a - b - cin, where cin
//   is a borrow in, and cout reports the borrow out.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
`ifdef CLA_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int  STAGES  = (GROUP > 0) ? (WIDTH / GROUP) : 1;
    localparam int  LAST    = STAGES - 1;
    localparam bit  BAD_CFG = (GROUP < 1) ? 1'b1 : ((WIDTH % GROUP) != 0);

    if (BAD_CFG) begin : g_bad_cfg
        $error("pipelined_cla_adder: WIDTH must be a positive multiple of GROUP (GROUP >= 1)");
    end

    // Flat sum-of-products carries for one slice: c[i] is the OR of every
    // generate term propagated up to bit i, plus the slice carry-in
    // propagated through all lower bits. No carry ripples between bits.
    function automatic logic [GROUP:0] cla_carries(
        input logic [GROUP-1:0] g,
        input logic [GROUP-1:0] p,
        input logic             c0
    );
        logic [GROUP:0] c;
        logic           term;
        c    = '0;
        c[0] = c0;
        for (int i = 1; i <= GROUP; i++) begin
            term = c0;
            for (int j = 0; j < i; j++) term = term & p[j];
            c[i] = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int m = j + 1; m < i; m++) term = term & p[m];
                c[i] = c[i] | term;
            end
        end
        return c;
    endfunction

    // Subtraction select; tied low when the add/sub option is not built.
    logic sub_in;
`ifdef CLA_ADD_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    // Stage registers: output of stage k. Operands travel unprocessed until
    // their slice is reached; finished lower sum slices travel alongside.
    logic             vld_p [STAGES];
    logic [WIDTH-1:0] a_p   [STAGES];
    logic [WIDTH-1:0] b_p   [STAGES];
    logic [WIDTH-1:0] sum_p [STAGES];
    logic             cy_p  [STAGES];
    logic             sub_p [STAGES];
    logic             ovf_p;

    // Stage inputs: ports for stage 0, previous stage register otherwise.
    logic             st_v   [STAGES];
    logic [WIDTH-1:0] st_a   [STAGES];
    logic [WIDTH-1:0] st_b   [STAGES];
    logic             st_c   [STAGES];
    logic [WIDTH-1:0] st_sum [STAGES];
    logic             st_sub [STAGES];

    // Stage results.
    logic [WIDTH-1:0] sum_n [STAGES];
    logic             cy_n  [STAGES];
    logic             ovf_n;

    logic adv;

    // Handshake: the whole pipeline moves only when the output slot frees up.
    assign in_ready = out_ready || !out_valid;
    assign adv      = in_ready;

    // Select each stage's inputs; subtraction inverts b and the carry-in once
    // at entry so every slice is a plain adder.
    always_comb begin
        st_v[0]   = in_valid;
        st_a[0]   = a;
        st_b[0]   = sub_in ? ~b : b;
        st_c[0]   = sub_in ? ~cin : cin;
        st_sum[0] = '0;
        st_sub[0] = sub_in;
        for (int k = 1; k < STAGES; k++) begin
            st_v[k]   = vld_p[k-1];
            st_a[k]   = a_p[k-1];
            st_b[k]   = b_p[k-1];
            st_c[k]   = cy_p[k-1];
            st_sum[k] = sum_p[k-1];
            st_sub[k] = sub_p[k-1];
        end
    end

    // Per-stage CLA slice; the final slice also forms the signed overflow
    // from the carry into and out of the MSB.
    always_comb begin
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   c;
        ovf_n = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            g        = st_a[k][k*GROUP +: GROUP] & st_b[k][k*GROUP +: GROUP];
            p        = st_a[k][k*GROUP +: GROUP] ^ st_b[k][k*GROUP +: GROUP];
            c        = cla_carries(g, p, st_c[k]);
            sum_n[k] = st_sum[k];
            sum_n[k][k*GROUP +: GROUP] = p ^ c[GROUP-1:0];
            cy_n[k]  = c[GROUP];
            if (k == LAST) ovf_n = c[GROUP-1] ^ c[GROUP];
        end
    end

    // Pipeline advance: valid bits always shift on adv; the output stage only
    // loads data for a valid operation so results hold across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) vld_p[k] <= 1'b0;
            sum_p[LAST] <= '0;
            cy_p[LAST]  <= 1'b0;
            sub_p[LAST] <= 1'b0;
            ovf_p       <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_p[k] <= st_v[k];
                if (k != LAST) begin
                    a_p[k]   <= st_a[k];
                    b_p[k]   <= st_b[k];
                    sum_p[k] <= sum_n[k];
                    cy_p[k]  <= cy_n[k];
                    sub_p[k] <= st_sub[k];
                end else if (st_v[k]) begin
                    sum_p[k] <= sum_n[k];
                    cy_p[k]  <= cy_n[k];
                    sub_p[k] <= st_sub[k];
                    ovf_p    <= ovf_n;
                end
            end
        end
    end

    assign out_valid = vld_p[LAST];
    assign sum       = sum_p[LAST];
    assign cout      = cy_p[LAST] ^ sub_p[LAST];
    assign ovf       = ovf_p;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: directed-vector bench for pipelined_cla_adder
// (WIDTH=16, GROUP=4, latency 4). Build with CLA_ADD_SUB_EN to also cover
// the subtraction path.
module tb_pipelined_cla_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
`ifdef CLA_ADD_SUB_EN
    logic        sub = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef CLA_ADD_SUB_EN
        .sub      (sub),
`endif
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Compare one observed value with its expected value.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] av, input logic [15:0] bv, input logic cv);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        cin      = cv;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        a        = 16'h0000;
        b        = 16'h0000;
        cin      = 1'b0;
    endtask

    task automatic chk_res(input string tag, input logic [15:0] s, input logic c, input logic v);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".sum"},   {16'd0, sum},       {16'd0, s});
        chk({tag, ".cout"},  {31'd0, cout},      {31'd0, c});
        chk({tag, ".ovf"},   {31'd0, ovf},       {31'd0, v});
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        idle();

        // Reset state
        tick();
        tick();
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.sum",       {16'd0, sum},       32'd0);
        chk("rst.cout",      {31'd0, cout},      32'd0);
        chk("rst.ovf",       {31'd0, ovf},       32'd0);
        rst = 1'b0;
        tick();
        chk("rst.in_ready",  {31'd0, in_ready},  32'd1);

        // Single add, latency 4
        drive(16'hFFFF, 16'h0001, 1'b0);
        tick();
        idle();
        tick();
        tick();
        chk("lat.early_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk_res("lat", 16'h0000, 1'b1, 1'b0);
        tick();
        chk("lat.after_valid", {31'd0, out_valid}, 32'd0);
        chk("lat.hold_sum",    {16'd0, sum},       32'h0000);

        // Back-to-back throughput
        drive(16'h7FFF, 16'h0001, 1'b0);
        tick();
        drive(16'h1234, 16'h4321, 1'b1);
        tick();
        drive(16'h8000, 16'h8000, 1'b0);
        tick();
        idle();
        tick();
        chk_res("b2b0", 16'h8000, 1'b0, 1'b1);
        tick();
        chk_res("b2b1", 16'h5556, 1'b0, 1'b0);
        tick();
        chk_res("b2b2", 16'h0000, 1'b1, 1'b1);
        tick();
        chk("b2b.drain_valid", {31'd0, out_valid}, 32'd0);

        // Stall: fill with four ops, then hold out_ready low for 5 cycles
        drive(16'h0001, 16'h0002, 1'b0);
        tick();
        drive(16'h00FF, 16'h0001, 1'b0);
        tick();
        drive(16'hF000, 16'h1000, 1'b0);
        tick();
        drive(16'h4000, 16'h4000, 1'b0);
        tick();
        out_ready = 1'b0;
        drive(16'hFFFF, 16'hFFFF, 1'b1);
        #1;
        chk_res("stl0", 16'h0003, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stl.in_ready",  {31'd0, in_ready},  32'd0);
            chk("stl.out_valid", {31'd0, out_valid}, 32'd1);
            chk("stl.sum",       {16'd0, sum},       32'h0003);
        end
        out_ready = 1'b1;
        #1;
        chk("stl.release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        drive(16'h0123, 16'h0456, 1'b0);
        chk_res("stl1", 16'h0100, 1'b0, 1'b0);
        tick();
        idle();
        chk_res("stl2", 16'h0000, 1'b1, 1'b0);
        tick();
        chk_res("stl3", 16'h8000, 1'b0, 1'b1);
        tick();
        chk_res("stl4", 16'hFFFF, 1'b1, 1'b0);
        tick();
        chk_res("stl5", 16'h0579, 1'b0, 1'b0);
        tick();
        chk("stl.drain_valid", {31'd0, out_valid}, 32'd0);

        // Bubble: in_valid 1,0,1
        drive(16'h0002, 16'h0003, 1'b0);
        tick();
        idle();
        tick();
        drive(16'h0010, 16'h0020, 1'b0);
        tick();
        idle();
        tick();
        chk_res("bub0", 16'h0005, 1'b0, 1'b0);
        tick();
        chk("bub.gap_valid", {31'd0, out_valid}, 32'd0);
        chk("bub.gap_sum",   {16'd0, sum},       32'h0005);
        tick();
        chk_res("bub1", 16'h0030, 1'b0, 1'b0);
        tick();

        // Reset with three operations in flight
        drive(16'h1111, 16'h1111, 1'b0);
        tick();
        drive(16'h2222, 16'h2222, 1'b0);
        tick();
        drive(16'h3333, 16'h3333, 1'b0);
        tick();
        idle();
        rst = 1'b1;
        tick();
        chk("mrst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst.sum",       {16'd0, sum},       32'h0000);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mrst.no_stale", {31'd0, out_valid}, 32'd0);
        end

`ifdef CLA_ADD_SUB_EN
        // Subtraction: 5 - 7 - 0
        sub = 1'b1;
        drive(16'h0005, 16'h0007, 1'b0);
        tick();
        idle();
        sub = 1'b0;
        tick();
        tick();
        tick();
        chk_res("sub", 16'hFFFE, 1'b1, 1'b0);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
